cpu_bus_sequencer: RTL and testbench

- Sequences external 8088-style minimum-mode bus cycles into single-beat requests toward the core-clock fabric (AXI bridge or Z80/CPU-side memory port).
- Synchronizes CPU pins, latches address on ALE, stalls the CPU via READY until the backend acknowledges, and drives read data onto AD.
- Sits between the Arduino-header CPU pins and the axi_devs memory/IO path, in the CLK_CORE domain.

---
 rtl/cpu_bus_pkg.sv | 31 +++
 rtl/sync_bits.sv | 33 +++
 rtl/cpu_bus_sequencer.sv | 233 +++++++++++++++++++++++
 tb/tb_cpu_bus_sequencer.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_bus_pkg.sv
// Shared types and constants for the 8088 minimum-mode bus sequencer.
package cpu_bus_pkg;

  localparam int CPU_DATA_W = 8;
  localparam int CPU_ADDR_W = 20;

  // Value returned to the CPU when the backend never answers.
  localparam logic [CPU_DATA_W-1:0] OPEN_BUS_DATA = 8'hFF;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ADDR     = 3'd1,
    STROBE   = 3'd2,
    WAIT_ACK = 3'd3,
    HOLD     = 3'd4
  } state_t;

  // Request fields presented to the backend while bus_req is high.
  typedef struct packed {
    logic                  we;
    logic                  io;
    logic [CPU_ADDR_W-1:0] addr;
    logic [CPU_DATA_W-1:0] wdata;
  } bus_req_t;

  // Width of the WAIT_ACK cycle counter for a given timeout.
  function automatic int timeout_cnt_w(input int cycles);
    return $clog2(cycles) + 1;
  endfunction

endpackage

// File: rtl/sync_bits.sv
// Multi-bit flop-chain synchronizer with a per-bit reset value.
// Each bit is synchronized independently; callers must only use buses whose
// value is stable around the sampling point (AD/A are held across ALE fall).
module sync_bits #(
  parameter int                WIDTH     = 1,
  parameter int                STAGES    = 2,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [STAGES];

  // Shift the asynchronous input through STAGES flops.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < STAGES; i++) begin
        stage_q[i] <= RESET_VAL;
      end
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/cpu_bus_sequencer.sv
// Turns 8088 minimum-mode bus cycles (ALE / nRD / nWR / IO-nM) seen on
// asynchronous pins into single-beat requests for the core-clock fabric.
// The CPU is held off with READY until the backend acknowledges; read data
// is driven back onto AD until the CPU lifts its strobe.
//
// Backend handshake: bus_req is a level held high, together with a stable
// bus_we/bus_io/bus_addr/bus_wdata, from the issuing edge until the first
// edge at which bus_ack is sampled high (which may be the first request
// cycle). bus_ack is a one-cycle pulse carrying bus_rdata; an ack while
// bus_req is low is ignored.
module cpu_bus_sequencer
  import cpu_bus_pkg::*;
#(
  parameter int                    SYNC_STAGES    = 2,
  parameter int                    ADDR_WIDTH     = 20,
  parameter int                    TIMEOUT_CYCLES = 1024,
  parameter logic [CPU_DATA_W-1:0] TIMEOUT_DATA   = OPEN_BUS_DATA
) (
  input  logic                    CLK_CORE,
  input  logic                    RESET,
  input  logic                    cpu_ale,
  input  logic                    cpu_rd_n,
  input  logic                    cpu_wr_n,
  input  logic                    cpu_io_m,
  input  logic [ADDR_WIDTH-9:0]   cpu_a_hi,
  input  logic [CPU_DATA_W-1:0]   cpu_ad_in,
  output logic [CPU_DATA_W-1:0]   cpu_ad_out,
  output logic                    cpu_ad_oe,
  output logic                    cpu_ready,
  output logic                    bus_req,
  output logic                    bus_we,
  output logic                    bus_io,
  output logic [ADDR_WIDTH-1:0]   bus_addr,
  output logic [CPU_DATA_W-1:0]   bus_wdata,
  input  logic                    bus_ack,
  input  logic [CPU_DATA_W-1:0]   bus_rdata,
  output logic                    busy,
  output logic                    timeout_err,
  output state_t                  dbg_state
);

  localparam int                CNT_W    = timeout_cnt_w(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  // The request struct carries a fixed-width address field.
  if (ADDR_WIDTH != CPU_ADDR_W) begin : g_addr_width_check
    $error("cpu_bus_sequencer: ADDR_WIDTH must equal CPU_ADDR_W");
  end

  // ---------------------------------------------------------------------
  // Pin synchronizers: control pins idle at ALE=0, nRD=1, nWR=1, IO/nM=0.
  // ---------------------------------------------------------------------
  logic [3:0]            ctrl_s;
  logic [ADDR_WIDTH-1:0] addr_data_s;

  sync_bits #(
    .WIDTH     (4),
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (4'b0110)
  ) u_sync_ctrl (
    .clk_i (CLK_CORE),
    .rst_i (RESET),
    .d_i   ({cpu_ale, cpu_rd_n, cpu_wr_n, cpu_io_m}),
    .q_o   (ctrl_s)
  );

  sync_bits #(
    .WIDTH     (ADDR_WIDTH),
    .STAGES    (SYNC_STAGES),
    .RESET_VAL ('0)
  ) u_sync_ad (
    .clk_i (CLK_CORE),
    .rst_i (RESET),
    .d_i   ({cpu_a_hi, cpu_ad_in}),
    .q_o   (addr_data_s)
  );

  logic                  ale_s;
  logic                  rd_n_s;
  logic                  wr_n_s;
  logic                  io_m_s;
  logic [CPU_DATA_W-1:0] ad_s;

  assign ale_s  = ctrl_s[3];
  assign rd_n_s = ctrl_s[2];
  assign wr_n_s = ctrl_s[1];
  assign io_m_s = ctrl_s[0];
  assign ad_s   = addr_data_s[CPU_DATA_W-1:0];

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  state_t                state_q,   state_d;
  logic                  ale_q;
  bus_req_t              req_q,     req_d;
  logic                  req_v_q,   req_v_d;
  logic                  ready_q,   ready_d;
  logic                  oe_q,      oe_d;
  logic [CPU_DATA_W-1:0] ad_out_q,  ad_out_d;
  logic                  tout_q,    tout_d;
  logic [CNT_W-1:0]      cnt_q,     cnt_d;

  logic ale_rise;
  logic ale_fall;
  logic strobe_done;

  assign ale_rise    = ale_s & ~ale_q;
  assign ale_fall    = ~ale_s & ale_q;
  // In HOLD the strobe that started the cycle decides when it ends.
  assign strobe_done = req_q.we ? wr_n_s : rd_n_s;

  // Next-state and registered-output logic for the bus-cycle FSM.
  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    req_v_d  = req_v_q;
    ready_d  = ready_q;
    oe_d     = oe_q;
    ad_out_d = ad_out_q;
    tout_d   = 1'b0;
    cnt_d    = '0;

    unique case (state_q)
      IDLE: begin
        if (ale_s) begin
          ready_d = 1'b0;
          state_d = ADDR;
        end
      end

      ADDR: begin
        if (ale_fall) begin
          req_d.addr = {addr_data_s[ADDR_WIDTH-1:CPU_DATA_W], ad_s};
          req_d.io   = io_m_s;
          state_d    = STROBE;
        end
      end

      STROBE: begin
        if (!rd_n_s) begin
          // A read wins if both strobes are seen low together.
          req_d.we = 1'b0;
          req_v_d  = 1'b1;
          state_d  = WAIT_ACK;
        end else if (!wr_n_s) begin
          req_d.we    = 1'b1;
          req_d.wdata = ad_s;
          req_v_d     = 1'b1;
          state_d     = WAIT_ACK;
        end else if (ale_rise) begin
          state_d = ADDR;
        end
      end

      WAIT_ACK: begin
        if (bus_ack && req_v_q) begin
          req_v_d = 1'b0;
          ready_d = 1'b1;
          if (!req_q.we) begin
            ad_out_d = bus_rdata;
            oe_d     = 1'b1;
          end
          state_d = HOLD;
        end else if (cnt_q == CNT_LAST) begin
          req_v_d = 1'b0;
          ready_d = 1'b1;
          tout_d  = 1'b1;
          if (!req_q.we) begin
            ad_out_d = TIMEOUT_DATA;
            oe_d     = 1'b1;
          end
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      HOLD: begin
        if (ale_s) begin
          // New ALE before the strobe lifted: drop AD and start over.
          oe_d    = 1'b0;
          ready_d = 1'b0;
          state_d = ADDR;
        end else if (strobe_done) begin
          oe_d    = 1'b0;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM state and output registers; reset aborts any cycle in flight.
  always_ff @(posedge CLK_CORE) begin
    if (RESET) begin
      state_q  <= IDLE;
      ale_q    <= 1'b0;
      req_q    <= '0;
      req_v_q  <= 1'b0;
      ready_q  <= 1'b1;
      oe_q     <= 1'b0;
      ad_out_q <= '0;
      tout_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      ale_q    <= ale_s;
      req_q    <= req_d;
      req_v_q  <= req_v_d;
      ready_q  <= ready_d;
      oe_q     <= oe_d;
      ad_out_q <= ad_out_d;
      tout_q   <= tout_d;
      cnt_q    <= cnt_d;
    end
  end

  assign cpu_ad_out  = ad_out_q;
  assign cpu_ad_oe   = oe_q;
  assign cpu_ready   = ready_q;
  assign bus_req     = req_v_q;
  assign bus_we      = req_q.we;
  assign bus_io      = req_q.io;
  assign bus_addr    = req_q.addr;
  assign bus_wdata   = req_q.wdata;
  assign busy        = (state_q != IDLE);
  assign timeout_err = tout_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_cpu_bus_sequencer.sv
// Bench for cpu_bus_sequencer: drives 8088 bus cycles on the pins, models
// the backend ack, and scoreboards issued requests and returned read data.
module tb_cpu_bus_sequencer;
  import cpu_bus_pkg::*;

  localparam int SYNC = 2;
  localparam int AW   = 20;
  localparam int TO   = 16;
  localparam int EW   = 2 + AW + 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            ale, rd_n, wr_n, io_m;
  logic [AW-9:0]   a_hi;
  logic [7:0]      ad_in;
  logic [7:0]      cpu_ad_out;
  logic            cpu_ad_oe, cpu_ready;
  logic            bus_req, bus_we, bus_io;
  logic [AW-1:0]   bus_addr;
  logic [7:0]      bus_wdata;
  logic            bus_ack;
  logic [7:0]      bus_rdata;
  logic            busy, timeout_err;
  state_t          dbg_state;

  int checks   = 0;
  int failures = 0;
  int tout_pulses = 0;

  logic [EW-1:0] exp_q[$];   // {we, io, addr, wdata}
  logic [7:0]    rd_q[$];    // data expected on AD when oe rises

  cpu_bus_sequencer #(
    .SYNC_STAGES    (SYNC),
    .ADDR_WIDTH     (AW),
    .TIMEOUT_CYCLES (TO),
    .TIMEOUT_DATA   (8'hFF)
  ) dut (
    .CLK_CORE    (clk),
    .RESET       (rst),
    .cpu_ale     (ale),
    .cpu_rd_n    (rd_n),
    .cpu_wr_n    (wr_n),
    .cpu_io_m    (io_m),
    .cpu_a_hi    (a_hi),
    .cpu_ad_in   (ad_in),
    .cpu_ad_out  (cpu_ad_out),
    .cpu_ad_oe   (cpu_ad_oe),
    .cpu_ready   (cpu_ready),
    .bus_req     (bus_req),
    .bus_we      (bus_we),
    .bus_io      (bus_io),
    .bus_addr    (bus_addr),
    .bus_wdata   (bus_wdata),
    .bus_ack     (bus_ack),
    .bus_rdata   (bus_rdata),
    .busy        (busy),
    .timeout_err (timeout_err),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checker ----------------
  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  logic          req_prev = 1'b0;
  logic          oe_prev  = 1'b0;
  logic [EW-1:0] mon_e;

  always @(negedge clk) begin
    if (bus_req && !req_prev) begin
      if (exp_q.size() == 0) begin
        check_val("unexp_req", 32'(bus_req), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check_val("req_we",   32'(bus_we),   32'(mon_e[EW-1]));
        check_val("req_io",   32'(bus_io),   32'(mon_e[EW-2]));
        check_val("req_addr", 32'(bus_addr), 32'(mon_e[EW-3:8]));
        if (mon_e[EW-1]) check_val("req_wdata", 32'(bus_wdata), 32'(mon_e[7:0]));
      end
    end
    if (cpu_ad_oe && !oe_prev) begin
      if (rd_q.size() == 0) check_val("unexp_oe", 32'(cpu_ad_oe), 32'd0);
      else                  check_val("rd_data", 32'(cpu_ad_out), 32'(rd_q.pop_front()));
    end
    if (timeout_err) tout_pulses++;
    req_prev = bus_req;
    oe_prev  = cpu_ad_oe;
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic addr_phase(input logic [AW-1:0] a, input logic io);
    a_hi  = a[AW-1:8];
    ad_in = a[7:0];
    io_m  = io;
    ale   = 1'b1;
    cyc(2);
    ale = 1'b0;
    cyc(2);
    check_val("ready_low_addr", 32'(cpu_ready), 32'd0);
  endtask

  // Address phase, strobe(s), wait for bus_req; queues expectations.
  task automatic start_cycle(input logic rd, input logic wr, input logic io,
                             input logic [AW-1:0] a, input logic [7:0] wd,
                             input logic [7:0] exp_rdata);
    int lat;
    addr_phase(a, io);
    exp_q.push_back({~rd, io, a, wd});
    if (rd) rd_q.push_back(exp_rdata);
    if (wr) ad_in = wd;
    if (rd) rd_n = 1'b0;
    if (wr) wr_n = 1'b0;
    lat = 0;
    while (lat < 20) begin
      cyc(1);
      lat++;
      if (bus_req) break;
    end
    check_val("req_latency", 32'(lat), 32'(SYNC + 1));
  endtask

  // Backend: ack after dly request cycles (dly<0 means never ack).
  task automatic ack_phase(input int dly, input logic is_rd, input logic [AW-1:0] a,
                           input logic [7:0] rdata);
    int n;
    n = 0;
    while (bus_req && n < 100) begin
      check_val("ready_low_req", 32'(cpu_ready), 32'd0);
      check_val("addr_stable",   32'(bus_addr),  32'(a));
      bus_ack   = (dly >= 0 && n == dly);
      bus_rdata = bus_ack ? rdata : 8'($urandom_range(0, 255));
      n++;
      cyc(1);
      bus_ack = 1'b0;
    end
    check_val("req_cycles", 32'(n), 32'((dly >= 0) ? dly + 1 : TO));
    check_val("ready_done", 32'(cpu_ready), 32'd1);
    check_val("oe_done",    32'(cpu_ad_oe), 32'(is_rd));
    if (is_rd) check_val("ad_out_done", 32'(cpu_ad_out), 32'((dly >= 0) ? rdata : 8'hFF));
    check_val("timeout_err", 32'(timeout_err), 32'(dly < 0));
  endtask

  task automatic release_phase();
    int n;
    rd_n = 1'b1;
    wr_n = 1'b1;
    n = 0;
    while (n < 20) begin
      cyc(1);
      n++;
      if (!busy) break;
    end
    check_val("release_lat", 32'(n), 32'(SYNC + 1));
    check_val("oe_released", 32'(cpu_ad_oe), 32'd0);
    check_val("ready_idle",  32'(cpu_ready), 32'd1);
  endtask

  task automatic bus_txn(input logic rd, input logic wr, input logic io,
                         input logic [AW-1:0] a, input logic [7:0] wd,
                         input logic [7:0] rdata, input int dly);
    start_cycle(rd, wr, io, a, wd, (dly >= 0) ? rdata : 8'hFF);
    ack_phase(dly, rd, a, rdata);
    cyc(2);
    check_val("oe_hold", 32'(cpu_ad_oe), 32'(rd));
    check_val("busy_hold", 32'(busy), 32'd1);
    release_phase();
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    check_val("rst_busy",  32'(busy),      32'd0);
    check_val("rst_req",   32'(bus_req),   32'd0);
    check_val("rst_oe",    32'(cpu_ad_oe), 32'd0);
    check_val("rst_ready", 32'(cpu_ready), 32'd1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1; ale = 1'b0; rd_n = 1'b1; wr_n = 1'b1; io_m = 1'b0;
    a_hi = '0; ad_in = '0; bus_ack = 1'b0; bus_rdata = '0;
    cyc(3);
    check_val("reset_ready",  32'(cpu_ready),   32'd1);
    check_val("reset_oe",     32'(cpu_ad_oe),   32'd0);
    check_val("reset_ad_out", 32'(cpu_ad_out),  32'd0);
    check_val("reset_req",    32'(bus_req),     32'd0);
    check_val("reset_we",     32'(bus_we),      32'd0);
    check_val("reset_io",     32'(bus_io),      32'd0);
    check_val("reset_addr",   32'(bus_addr),    32'd0);
    check_val("reset_wdata",  32'(bus_wdata),   32'd0);
    check_val("reset_tout",   32'(timeout_err), 32'd0);
    check_val("reset_busy",   32'(busy),        32'd0);
    rst = 1'b0;
    cyc(1);

    // Stray strobe without ALE, and an ack while nothing is requested.
    rd_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cyc(1);
      check_val("stray_req",  32'(bus_req), 32'd0);
      check_val("stray_busy", 32'(busy),    32'd0);
    end
    bus_ack = 1'b1; bus_rdata = 8'hA5;
    cyc(1);
    bus_ack = 1'b0;
    rd_n = 1'b1;
    cyc(4);
    check_val("stray_ready", 32'(cpu_ready),   32'd1);
    check_val("stray_oe",    32'(cpu_ad_oe),   32'd0);
    check_val("stray_addr",  32'(bus_addr),    32'd0);
    check_val("stray_out",   32'(cpu_ad_out),  32'd0);
    check_val("stray_busy2", 32'(busy),        32'd0);

    // Memory read, ack 3 cycles after req.
    bus_txn(1'b1, 1'b0, 1'b0, 20'h01234, 8'h00, 8'h5A, 3);
    // IO write, ack in the first request cycle.
    bus_txn(1'b0, 1'b1, 1'b1, 20'h00080, 8'hC3, 8'h00, 0);
    // Read with no ack: forced completion with open-bus data.
    bus_txn(1'b1, 1'b0, 1'b0, 20'h4_2100, 8'h00, 8'h00, -1);
    // Both strobes low: read wins.
    bus_txn(1'b1, 1'b1, 1'b0, 20'h2A5C7, 8'h99, 8'h6E, 2);

    // Reset during WAIT_ACK.
    start_cycle(1'b1, 1'b0, 1'b0, 20'h30F0F, 8'h00, 8'h11);
    cyc(2);
    check_val("pre_rst_req", 32'(bus_req), 32'd1);
    pulse_reset();
    rd_q.delete();
    rd_n = 1'b1;
    cyc(4);

    // Reset during HOLD.
    start_cycle(1'b1, 1'b0, 1'b0, 20'h05555, 8'h00, 8'h77);
    ack_phase(1, 1'b1, 20'h05555, 8'h77);
    cyc(1);
    pulse_reset();
    check_val("rst_ad_out", 32'(cpu_ad_out), 32'd0);
    rd_n = 1'b1;
    cyc(4);

    // Normal read after the aborted cycles.
    bus_txn(1'b1, 1'b0, 1'b0, 20'hFFFF0, 8'h00, 8'h3C, 1);

    // A few randomized transactions.
    for (int i = 0; i < 6; i++) begin
      logic          r, io;
      logic [AW-1:0] a;
      r  = 1'($urandom_range(0, 1));
      io = 1'($urandom_range(0, 1));
      a  = AW'($urandom_range(0, 20'hFFFFF));
      bus_txn(r, ~r, io, a, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
              int'($urandom_range(0, 4)));
    end

    cyc(2);
    check_val("tout_pulses", 32'(tout_pulses),   32'd1);
    check_val("exp_q_empty", 32'(exp_q.size()),  32'd0);
    check_val("rd_q_empty",  32'(rd_q.size()),   32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
